pattern_gen: RTL

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen_pkg.sv | 15 +
 rtl/pattern_gen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pattern_gen_pkg.sv
// Shared types and constants for the serial 1010 pattern generator.
package pattern_gen_pkg;

  // Controller states: waiting, shifting pattern bits, idle gap, completion pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // The pattern is sent MSB first, so bit index i maps to PATTERN[3-i].
  localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/pattern_gen.sv
// Serial 1010 pattern generator: sends 'count' patterns separated by 'gap'
// idle zeros, then pulses done. Every output is a flop so that downstream
// detectors see clean, glitch-free bits.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  output logic             dout,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [1:0]       bit_q, bit_d;
  logic [1:0]       bit_nx;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             dout_d, busy_d, done_d;

  assign bit_nx = bit_q + 2'd1;

  // Next-state logic; outputs are computed for the upcoming cycle and registered,
  // so the first pattern bit appears right after the edge that samples start.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    rem_d     = rem_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    dout_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d   = SEND;
            bit_d     = 2'd0;
            rem_d     = count;
            gap_len_d = gap;
            gap_cnt_d = '0;
            dout_d    = PATTERN[3];
            busy_d    = 1'b1;
          end else begin
            // Empty request: spend one quiet FIN cycle before the done pulse.
            state_d = FIN;
          end
        end
      end

      SEND: begin
        busy_d = 1'b1;
        if (bit_q != 2'd3) begin
          bit_d  = bit_nx;
          dout_d = PATTERN[~bit_nx];
        end else if (rem_q == CNT_W'(1)) begin
          state_d = FIN;
          bit_d   = 2'd0;
          rem_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - CNT_W'(1);
          bit_d = 2'd0;
          if (gap_len_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_len_q - GAP_W'(1);
          end else begin
            dout_d = PATTERN[3];
          end
        end
      end

      GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q == '0) begin
          state_d = SEND;
          bit_d   = 2'd0;
          dout_d  = PATTERN[3];
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      FIN: begin
        // Normal completion enters FIN with done already set; the empty
        // request enters with done low and raises it here one cycle later.
        if (done) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset wins over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_q     <= 2'd0;
      rem_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      dout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      rem_q     <= rem_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      dout      <= dout_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
